img_window_writeback: RTL and testbench

//  Write-side counterpart of the window fetcher: stores one processed 45x45

---
 rtl/img_window_writeback.sv | 113 +++++++++++
 tb/tb_img_window_writeback.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/img_window_writeback.sv
// img_window_writeback: writes one latched WINxWIN window into its tile slot of the output image region
module img_window_writeback #(
  parameter int WIN           = 45,
  parameter int TILES_PER_ROW = 4,
  parameter int TILES_PER_COL = 4,
  parameter int IMG_W         = TILES_PER_ROW * WIN,
  parameter int BASE_ADDR     = 60136
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [14:0]           tile_index,
  input  logic [WIN*WIN*8-1:0]  window,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ren,
  output logic                  wen,
  output logic [16:0]           addr,
  output logic [7:0]            din
);
  localparam int NPIX = WIN * WIN;
  localparam int IW   = $clog2(NPIX * 8);
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [NPIX*8-1:0] win_q;
  logic [14:0] tile_q, tile_d, t;
  logic [11:0] k_q, k_d, kn;
  logic [5:0]  c_q, c_d;
  logic [16:0] row_q, row_d, first, addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        wen_q, wen_d, err_q, err_d, bad_tile;
  assign t        = tile_q - 15'd1;
  assign kn       = k_q + 12'd1;
  assign bad_tile = tile_q == 15'd0 || tile_q > 15'(TILES_PER_ROW * TILES_PER_COL);
  // row_q tracks the address of pixel (r, 0) so each step is an add, never a divide
  assign first    = 17'(BASE_ADDR) + 17'(t / 15'(TILES_PER_ROW)) * 17'(WIN * IMG_W)
                  + 17'(t % 15'(TILES_PER_ROW)) * 17'(WIN);
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    k_d     = k_q;
    c_d     = c_q;
    row_d   = row_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? SETUP : IDLE;
        tile_d  = start ? tile_index : tile_q;
        err_d   = start ? 1'b0 : err_q;
      end
      SETUP: begin
        state_d = bad_tile ? DONE : WRITE;
        err_d   = bad_tile;
        wen_d   = !bad_tile;
        k_d     = 12'd0;
        c_d     = 6'd0;
        row_d   = first;
        addr_d  = bad_tile ? addr_q : first;
        din_d   = bad_tile ? din_q : win_q[7:0];
      end
      WRITE: begin
        if (k_q == 12'(NPIX - 1)) begin
          state_d = DONE;
        end else begin
          wen_d  = 1'b1;
          k_d    = kn;
          c_d    = c_q == 6'(WIN - 1) ? 6'd0 : c_q + 6'd1;
          row_d  = c_q == 6'(WIN - 1) ? row_q + 17'(IMG_W) : row_q;
          addr_d = c_q == 6'(WIN - 1) ? row_q + 17'(IMG_W) : row_q + 17'(c_q) + 17'd1;
          din_d  = win_q[IW'({kn, 3'b000}) +: 8];
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q  <= '0;
      k_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      k_q     <= k_d;
      c_q     <= c_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) win_q <= window;
  end
  assign busy = state_q == SETUP || state_q == WRITE;
  assign done = state_q == DONE;
  assign err  = done && err_q;
  assign ren  = 1'b0;
  assign wen  = wen_q;
  assign addr = addr_q;
  assign din  = din_q;
endmodule

// File: tb/tb_img_window_writeback.sv
// tb_img_window_writeback: table-driven and randomized requests checked against a tile/pixel address model
module tb_img_window_writeback;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [14:0] tile_index = '0;
  logic [16199:0] window = '0;
  logic busy, done, err, ren, wen;
  logic [16:0] addr;
  logic [7:0] din;
  int total = 0, bad = 0;
  int r_nwen, r_done, r_nbad;
  logic r_err, r_ren;
  logic [16:0] r_fa, r_la;
  logic [7:0] r_ld;
  logic [16199:0] cur_w, pat_w, w;
  typedef struct {
    logic [14:0] tile;
    int pat;
    int glitch;
    logic err;
    logic [16:0] fa;
    logic [16:0] la;
    logic [7:0] ld;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  img_window_writeback dut (
    .clk(clk), .rst(rst), .start(start), .tile_index(tile_index), .window(window),
    .busy(busy), .done(done), .err(err), .ren(ren), .wen(wen), .addr(addr), .din(din)
  );

  function automatic int exp_addr(int tile, int k);
    int t = tile - 1;
    return 60136 + ((t / 4) * 45 + k / 45) * 180 + (t % 4) * 45 + k % 45;
  endfunction

  function automatic logic [16199:0] rand_win();
    logic [16199:0] x;
    for (int i = 0; i < 2025; i++) x[8*i +: 8] = 8'($urandom);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_req(input logic [14:0] tile, input logic [16199:0] wv, input int glitch);
    r_nwen = 0; r_done = -1; r_nbad = 0; r_err = 1'b0; r_ren = 1'b0;
    r_fa = '0; r_la = '0; r_ld = '0; cur_w = wv;
    @(negedge clk);
    start = 1'b1; tile_index = tile; window = wv;
    @(posedge clk); #1;
    start = 1'b0; tile_index = 15'd3; window = ~wv;
    for (int j = 1; j <= 2100; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      if (ren) r_ren = 1'b1;
      if (wen) begin
        if (r_nwen != j - 2 || addr !== 17'(exp_addr(int'(tile), r_nwen)) || din !== wv[8*r_nwen +: 8])
          r_nbad++;
        if (r_nwen == 0) r_fa = addr;
        r_la = addr; r_ld = din; r_nwen++;
      end
      if (busy === done) r_nbad++;
      if (done) begin r_done = j; r_err = err; break; end
      if (j == glitch) begin start = 1'b1; tile_index = 15'd2; window = rand_win(); end
      if (j == glitch + 1) start = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_req(input string name, input logic e_err, input logic [16:0] fa,
                           input logic [16:0] la, input logic [7:0] ld);
    check({name, "_pixels"}, r_nbad, 0);
    check({name, "_nwen"}, r_nwen, e_err ? 0 : 2025);
    check({name, "_done_cyc"}, r_done, e_err ? 2 : 2027);
    check({name, "_err"}, 32'(r_err), 32'(e_err));
    check({name, "_ren"}, 32'(r_ren), 0);
    if (!e_err) begin
      check({name, "_first_addr"}, r_fa, fa);
      check({name, "_last_addr"}, r_la, la);
      check({name, "_last_din"}, r_ld, ld);
    end
  endtask

  initial begin
    logic [14:0] tl;
    logic e;
    int seen_done;
    for (int i = 0; i < 2025; i++) pat_w[8*i +: 8] = 8'(i);
    vecs[0] = '{15'd1,  0, -1,  1'b0, 17'd60136, 17'd68100, 8'd232};
    vecs[1] = '{15'd6,  1, -1,  1'b0, 17'd68281, 17'd76245, 8'd0};
    vecs[2] = '{15'd16, 1, -1,  1'b0, 17'd84571, 17'd92535, 8'd0};
    vecs[3] = '{15'd0,  1, -1,  1'b1, 17'd0,     17'd0,     8'd0};
    vecs[4] = '{15'd17, 1, -1,  1'b1, 17'd0,     17'd0,     8'd0};
    vecs[5] = '{15'd1,  1, 500, 1'b0, 17'd60136, 17'd68100, 8'd0};
    vecs[6] = '{15'd4,  0, -1,  1'b0, 17'd60271, 17'd68235, 8'd232};
    vecs[7] = '{15'd13, 0, -1,  1'b0, 17'd84436, 17'd92400, 8'd232};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, err, ren, wen, addr, din}), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = vecs[i].pat == 0 ? pat_w : rand_win();
      run_req(vecs[i].tile, w, vecs[i].glitch);
      check_req($sformatf("vec%0d", i), vecs[i].err, vecs[i].fa, vecs[i].la,
                vecs[i].pat == 0 ? vecs[i].ld : w[8*2024 +: 8]);
    end
    for (int i = 0; i < 3; i++) begin
      tl = 15'($urandom_range(0, 17));
      e = tl == 15'd0 || tl > 15'd16;
      w = rand_win();
      run_req(tl, w, -1);
      check_req($sformatf("rand%0d_tile%0d", i, tl), e, 17'(exp_addr(int'(tl), 0)),
                17'(exp_addr(int'(tl), 2024)), w[8*2024 +: 8]);
    end
    w = rand_win();
    @(negedge clk);
    start = 1'b1; tile_index = 15'd3; window = w;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (101) @(posedge clk);
    #1;
    check("rst_pre_wen", 32'(wen), 1);
    check("rst_pre_addr", addr, exp_addr(3, 100));
    check("rst_pre_din", din, w[8*100 +: 8]);
    rst = 1'b1;
    #1;
    check("rst_wen_drop", 32'(wen), 0);
    check("rst_busy_drop", 32'(busy), 0);
    check("rst_addr_zero", addr, 0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("rst_no_done", seen_done, 0);
    @(negedge clk) rst = 1'b0;
    w = rand_win();
    run_req(15'd1, w, -1);
    check_req("after_rst", 1'b0, 17'd60136, 17'd68100, w[8*2024 +: 8]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
